// File: rtl/ibex_multdiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Signal names follow the unit's port list; directions are seen from the unit (slave).
interface ibex_multdiv_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       operator_i;
    logic [1:0]       signed_mode_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             data_ind_timing_i;
    logic             kill_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             busy_o;

    modport master (
        output req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, data_ind_timing_i,
        output kill_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, data_ind_timing_i,
        input  kill_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// Iterative radix-2 multiply/divide engine: shift-add multiply, restoring divide,
// sign fixup at the end, optional early-out for short multipliers and divide by zero.
module ibex_multdiv_iter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input logic                clk_i,
    input logic                rst_ni,
    ibex_multdiv_iter_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {StIdle, StAbs, StComp, StFixup, StDone} state_e;

    state_e             state_q;
    logic [1:0]         op_q;
    logic               sign_a_q, sign_b_q, dz_q, dit_q, resp_valid_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opd_q, shf_q, result_q;
    logic [CntW-1:0]    cnt_q;

    logic accept, fast_dz, mul_eo, q_bit;
    logic [WIDTH-1:0]   mag_a, mag_b, mul_addend, fix_res;
    logic [WIDTH:0]     mul_sum, rem_shift, rem_new;
    logic [WIDTH+1:0]   rem_diff;
    logic [2*WIDTH-1:0] prod_al, prod_fx;

    assign bus.req_ready_o  = (state_q == StIdle);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.result_o     = result_q;

    assign accept  = bus.req_valid_i & bus.req_ready_o & ~bus.kill_i;
    assign fast_dz = EARLY_OUT & ~bus.data_ind_timing_i & bus.operator_i[1] &
                     (bus.op_b_i == '0);

    // Before ABS, opd_q holds raw op_a and shf_q holds raw op_b.
    assign mag_a = sign_a_q ? ({WIDTH{1'b0}} - opd_q) : opd_q;
    assign mag_b = sign_b_q ? ({WIDTH{1'b0}} - shf_q) : shf_q;

    // Multiply: opd_q = |a|, shf_q = remaining multiplier bits, product enters acc from the top.
    assign mul_addend = shf_q[0] ? opd_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_eo     = EARLY_OUT & ~dit_q & (shf_q[WIDTH-1:1] == '0);

    // Divide: opd_q = |b|, shf_q shifts dividend out of the top and quotient in at the bottom.
    assign rem_shift = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, opd_q};
    assign q_bit     = ~rem_diff[WIDTH+1];
    assign rem_new   = q_bit ? rem_diff[WIDTH:0] : rem_shift;

    // An early-out leaves the product cnt_q bits too high; realign before negating.
    assign prod_al = acc_q >> cnt_q;
    assign prod_fx = (sign_a_q ^ sign_b_q) ? ({(2*WIDTH){1'b0}} - prod_al) : prod_al;

    always_comb begin
        fix_res = '0;
        unique case (op_q)
            2'd0: fix_res = prod_fx[WIDTH-1:0];
            2'd1: fix_res = prod_fx[2*WIDTH-1:WIDTH];
            2'd2: fix_res = ((sign_a_q ^ sign_b_q) & ~dz_q) ? ({WIDTH{1'b0}} - shf_q) : shf_q;
            default: fix_res = sign_a_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            op_q         <= 2'd0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            dz_q         <= 1'b0;
            dit_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            acc_q        <= '0;
            opd_q        <= '0;
            shf_q        <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
        end else if (bus.kill_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q     <= bus.operator_i;
                        dit_q    <= bus.data_ind_timing_i;
                        sign_a_q <= bus.signed_mode_i[0] & bus.op_a_i[WIDTH-1];
                        sign_b_q <= bus.signed_mode_i[1] & bus.op_b_i[WIDTH-1];
                        dz_q     <= (bus.op_b_i == '0);
                        opd_q    <= bus.op_a_i;
                        shf_q    <= bus.op_b_i;
                        if (fast_dz) begin
                            result_q     <= bus.operator_i[0] ? bus.op_a_i : '1;
                            resp_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            state_q <= StAbs;
                        end
                    end
                end
                StAbs: begin
                    acc_q   <= '0;
                    cnt_q   <= CntW'(WIDTH);
                    opd_q   <= op_q[1] ? mag_b : mag_a;
                    shf_q   <= op_q[1] ? mag_a : mag_b;
                    state_q <= StComp;
                end
                StComp: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (op_q[1]) begin
                        acc_q <= {{(WIDTH-1){1'b0}}, rem_new};
                        shf_q <= {shf_q[WIDTH-2:0], q_bit};
                        if (cnt_q == CntW'(1)) state_q <= StFixup;
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                        shf_q <= {1'b0, shf_q[WIDTH-1:1]};
                        if (cnt_q == CntW'(1) || mul_eo) state_q <= StFixup;
                    end
                end
                StFixup: begin
                    result_q     <= fix_res;
                    resp_valid_q <= 1'b1;
                    state_q      <= StDone;
                end
                StDone: begin
                    if (bus.resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: 32-bit and 16-bit instances, results and latencies.
module tb_ibex_multdiv_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ibex_multdiv_iter_if #(.WIDTH(32)) bus32 ();
    ibex_multdiv_iter_if #(.WIDTH(16)) bus16 ();

    ibex_multdiv_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) u_dut32 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus32)
    );

    ibex_multdiv_iter #(.WIDTH(16), .EARLY_OUT(1'b1)) u_dut16 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus16)
    );

    // Issues one request, scrambles the inputs after accept, and waits for the response.
    // lat counts cycles from the accept edge: 1 means valid right after that edge.
    task automatic run32(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic dit, output logic [31:0] res,
                         output int lat);
        int n;
        @(negedge clk);
        bus32.req_valid_i = 1'b1;
        bus32.operator_i = op;
        bus32.signed_mode_i = mode;
        bus32.op_a_i = a;
        bus32.op_b_i = b;
        bus32.data_ind_timing_i = dit;
        n = 0;
        while (!bus32.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus32.req_valid_i = 1'b0;
        bus32.operator_i = ~op;
        bus32.signed_mode_i = ~mode;
        bus32.op_a_i = ~a;
        bus32.op_b_i = ~b;
        bus32.data_ind_timing_i = ~dit;
        lat = 1;
        while (!bus32.resp_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus32.resp_valid_o ? bus32.result_o : 'x;
        if (!bus32.resp_valid_o) lat = -1;
    endtask

    task automatic run16(input logic [1:0] op, input logic [1:0] mode, input logic [15:0] a,
                         input logic [15:0] b, input logic dit, output logic [15:0] res,
                         output int lat);
        int n;
        @(negedge clk);
        bus16.req_valid_i = 1'b1;
        bus16.operator_i = op;
        bus16.signed_mode_i = mode;
        bus16.op_a_i = a;
        bus16.op_b_i = b;
        bus16.data_ind_timing_i = dit;
        n = 0;
        while (!bus16.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus16.req_valid_i = 1'b0;
        bus16.op_a_i = ~a;
        bus16.op_b_i = ~b;
        lat = 1;
        while (!bus16.resp_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus16.resp_valid_o ? bus16.result_o : 'x;
        if (!bus16.resp_valid_o) lat = -1;
    endtask

    task automatic wait_idle32();
        int n = 0;
        @(negedge clk);
        while (!bus32.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus32.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", bus32.req_ready_o); end
        n_tests++; if (bus32.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %b want 0", bus32.resp_valid_o); end
        n_tests++; if (bus32.result_o !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h want 0", bus32.result_o); end
        n_tests++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus32.busy_o); end
        n_tests++; if (bus16.req_ready_o !== 1'b1 || bus16.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset w16: got rdy=%b vld=%b want 1 0", bus16.req_ready_o, bus16.resp_valid_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat;
        run32(2'd0, 2'b11, 32'hFFFFFFFD, 32'd7, 1'b1, r, lat);
        n_tests++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul -3*7: got %h want ffffffeb", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL mul -3*7 latency: got %0d want 35", lat); end
    endtask

    task automatic test_mulh();
        logic [31:0] r;
        int lat;
        run32(2'd1, 2'b11, 32'h80000000, 32'h80000000, 1'b0, r, lat);
        n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulh min*min: got %h want 40000000", r); end
        run32(2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu max*max: got %h want fffffffe", r); end
        run32(2'd1, 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu -1*2: got %h want ffffffff", r); end
        run32(2'd0, 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulsu low -1*2: got %h want fffffffe", r); end
    endtask

    task automatic test_early_out();
        logic [31:0] r;
        int lat;
        run32(2'd0, 2'b00, 32'd5, 32'd1, 1'b0, r, lat);
        n_tests++; if (r !== 32'd5) begin n_fail++; $display("FAIL eo 5*1: got %h want 5", r); end
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL eo 5*1 latency: got %0d want 4", lat); end
        run32(2'd0, 2'b00, 32'd5, 32'd1, 1'b1, r, lat);
        n_tests++; if (r !== 32'd5) begin n_fail++; $display("FAIL dit 5*1: got %h want 5", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL dit 5*1 latency: got %0d want 35", lat); end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int lat;
        run32(2'd2, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div -7/2: got %h want fffffffd", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL div -7/2 latency: got %0d want 35", lat); end
        run32(2'd3, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem -7%%2: got %h want ffffffff", r); end
        run32(2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
        n_tests++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div min/-1: got %h want 80000000", r); end
        run32(2'd3, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem min%%-1: got %h want 0", r); end
        run32(2'd2, 2'b00, 32'd100, 32'd7, 1'b0, r, lat);
        n_tests++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu 100/7: got %h want e", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r;
        int lat;
        run32(2'd2, 2'b11, 32'd55, 32'd0, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div x/0 fast: got %h want ffffffff", r); end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL div x/0 fast latency: got %0d want 1", lat); end
        run32(2'd3, 2'b11, 32'h1234, 32'd0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h1234) begin n_fail++; $display("FAIL rem x/0 fast: got %h want 1234", r); end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL rem x/0 fast latency: got %0d want 1", lat); end
        run32(2'd2, 2'b11, 32'd55, 32'd0, 1'b1, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div x/0 dit: got %h want ffffffff", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL div x/0 dit latency: got %0d want 35", lat); end
        run32(2'd3, 2'b11, 32'h1234, 32'd0, 1'b1, r, lat);
        n_tests++; if (r !== 32'h1234) begin n_fail++; $display("FAIL rem x/0 dit: got %h want 1234", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL rem x/0 dit latency: got %0d want 35", lat); end
        run32(2'd2, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div -5/0 dit: got %h want ffffffff", r); end
        run32(2'd3, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, r, lat);
        n_tests++; if (r !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL rem -5/0 dit: got %h want fffffffb", r); end
    endtask

    task automatic test_kill();
        logic [31:0] r;
        int lat;
        bit seen;
        wait_idle32();
        bus32.req_valid_i = 1'b1;
        bus32.operator_i = 2'd0;
        bus32.signed_mode_i = 2'b00;
        bus32.op_a_i = 32'd9;
        bus32.op_b_i = 32'd9;
        bus32.data_ind_timing_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.req_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_tests++; if (bus32.busy_o !== 1'b1) begin n_fail++; $display("FAIL kill busy before: got %b want 1", bus32.busy_o); end
        @(negedge clk);
        bus32.kill_i = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus32.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL kill req_ready: got %b want 1", bus32.req_ready_o); end
        n_tests++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL kill busy: got %b want 0", bus32.busy_o); end
        @(negedge clk);
        bus32.kill_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus32.resp_valid_o) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill no response: got resp_valid=%b want 0", seen); end
        run32(2'd0, 2'b11, 32'd6, 32'd7, 1'b0, r, lat);
        n_tests++; if (r !== 32'd42) begin n_fail++; $display("FAIL after kill 6*7: got %h want 2a", r); end
    endtask

    task automatic test_kill_accept();
        bit seen;
        wait_idle32();
        bus32.req_valid_i = 1'b1;
        bus32.kill_i = 1'b1;
        bus32.operator_i = 2'd0;
        bus32.op_a_i = 32'd3;
        bus32.op_b_i = 32'd3;
        @(posedge clk);
        #1;
        n_tests++; if (bus32.busy_o !== 1'b0) begin n_fail++; $display("FAIL kill+valid busy: got %b want 0", bus32.busy_o); end
        n_tests++; if (bus32.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL kill+valid ready: got %b want 1", bus32.req_ready_o); end
        @(negedge clk);
        bus32.req_valid_i = 1'b0;
        bus32.kill_i = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus32.resp_valid_o || bus32.busy_o) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill+valid activity: got %b want 0", seen); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int lat;
        bus32.resp_ready_i = 1'b0;
        run32(2'd2, 2'b00, 32'd100, 32'd7, 1'b0, r, lat);
        n_tests++; if (r !== 32'd14) begin n_fail++; $display("FAIL bp result: got %h want e", r); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_tests++; if (bus32.resp_valid_o !== 1'b1 || bus32.result_o !== 32'd14 || bus32.req_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp hold %0d: got vld=%b res=%h rdy=%b want 1 e 0", i, bus32.resp_valid_o, bus32.result_o, bus32.req_ready_o); end
        end
        @(negedge clk);
        bus32.resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus32.resp_valid_o !== 1'b0 || bus32.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp release: got vld=%b rdy=%b want 0 1", bus32.resp_valid_o, bus32.req_ready_o); end
        // A kill while a response is pending drops it.
        bus32.resp_ready_i = 1'b0;
        run32(2'd3, 2'b00, 32'd100, 32'd7, 1'b0, r, lat);
        n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu 100%%7: got %h want 2", r); end
        @(negedge clk);
        bus32.kill_i = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus32.resp_valid_o !== 1'b0 || bus32.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL kill in done: got vld=%b rdy=%b want 0 1", bus32.resp_valid_o, bus32.req_ready_o); end
        @(negedge clk);
        bus32.kill_i = 1'b0;
        bus32.resp_ready_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat;
        run32(2'd0, 2'b00, 32'h00010001, 32'h00010001, 1'b1, r, lat);
        n_tests++; if (r !== 32'h00020001) begin n_fail++; $display("FAIL b2b mul: got %h want 00020001", r); end
        run32(2'd2, 2'b00, 32'hFFFFFFFF, 32'd16, 1'b1, r, lat);
        n_tests++; if (r !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL b2b divu: got %h want 0fffffff", r); end
        n_tests++; if (lat != 35) begin n_fail++; $display("FAIL b2b divu latency: got %0d want 35", lat); end
    endtask

    task automatic test_width16();
        logic [15:0] r;
        int lat;
        run16(2'd2, 2'b11, 16'hFFF9, 16'h0002, 1'b1, r, lat);
        n_tests++; if (r !== 16'hFFFD) begin n_fail++; $display("FAIL w16 div: got %h want fffd", r); end
        n_tests++; if (lat != 19) begin n_fail++; $display("FAIL w16 div latency: got %0d want 19", lat); end
        run16(2'd1, 2'b11, 16'hFFFD, 16'd7, 1'b1, r, lat);
        n_tests++; if (r !== 16'hFFFF) begin n_fail++; $display("FAIL w16 mulh -3*7: got %h want ffff", r); end
    endtask

    initial begin
        bus32.req_valid_i = 1'b0;
        bus32.operator_i = 2'd0;
        bus32.signed_mode_i = 2'b00;
        bus32.op_a_i = '0;
        bus32.op_b_i = '0;
        bus32.data_ind_timing_i = 1'b0;
        bus32.kill_i = 1'b0;
        bus32.resp_ready_i = 1'b1;
        bus16.req_valid_i = 1'b0;
        bus16.operator_i = 2'd0;
        bus16.signed_mode_i = 2'b00;
        bus16.op_a_i = '0;
        bus16.op_b_i = '0;
        bus16.data_ind_timing_i = 1'b0;
        bus16.kill_i = 1'b0;
        bus16.resp_ready_i = 1'b1;
        test_reset();
        test_mul();
        test_mulh();
        test_early_out();
        test_div();
        test_div_zero();
        test_kill();
        test_kill_accept();
        test_backpressure();
        test_back_to_back();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_multdiv_iter.md
Name: ibex_multdiv_iter

Overview:
Self-contained, parametrised iterative multiply/divide unit. Successor to the ALU-sharing slow multdiv: it owns its adder and intermediate registers, supports any operand width, and uses valid/ready request/response handshakes with a kill input. It sits beside the ID/EX stage as a standalone M-extension engine and provides data-independent-timing and early-out modes.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- EARLY_OUT, 1, enables variable-latency shortcuts (multiply early-out, divide-by-zero fast path) when data_ind_timing_i=0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- operator_i  in  2  0=MUL (low word), 1=MULH (high word), 2=DIV, 3=REM
- signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
- op_a_i  in  WIDTH  multiplicand / dividend
- op_b_i  in  WIDTH  multiplier / divisor
- data_ind_timing_i  in  1  forces fixed latency; sampled at accept
- kill_i  in  1  abort in-flight operation
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, req_ready_o=1, resp_valid_o=0, result_o=0, busy_o=0. All datapath registers cleared.
- Accept: a request is accepted when req_valid_i & req_ready_o & ~kill_i. req_ready_o = (state==IDLE).
- Latching at accept: operator, signed mode, operands and data_ind_timing are captured. Later input changes are ignored.
- Internal registers: accumulator (2*WIDTH), shift operand (WIDTH), counter ($clog2(WIDTH)+1 bits), sign flags, div_by_zero flag.
- State machine:
  - IDLE -> ABS on accept.
  - ABS (1 cycle): take magnitudes of signed operands via the internal adder (0 - x); init counter=WIDTH.
  - COMP: one radix-2 step per cycle; counter decrements.
    - MUL/MULH: shift-add of |a| by |b| bits, LSB first.
    - DIV/REM: restoring division. Shift the remainder left with the next dividend bit; subtract |b| if the difference is ≥ 0 and set the quotient bit.
    - Exit to FIXUP when counter reaches 0.
    - Multiply early-out: if EARLY_OUT & ~dit and all remaining multiplier bits are 0, exit after the current step. At least 1 COMP cycle always runs.
  - FIXUP (1 cycle): negate the result if required.
    - MUL/MULH: negate the 2*WIDTH product if sign_a ^ sign_b.
    - DIV: negate the quotient if (sign_a ^ sign_b) & ~div_by_zero.
    - REM: negate the remainder if sign_a.
  - DONE: resp_valid_o=1; result_o is held stable. Go to IDLE on resp_ready_i. The next request is accepted no earlier than the following cycle (no bypass).
- Fixed latency: accept edge T -> resp_valid_o high in cycle T+WIDTH+3.
- Divide by zero:
  - DIV returns all-ones; REM returns op_a.
  - With EARLY_OUT & ~dit: IDLE -> DONE directly, resp_valid_o at T+1.
  - Otherwise the full iteration runs and produces the same values naturally; the FIXUP sign change is suppressed for DIV.
- Signed overflow: MIN / -1 gives DIV=MIN, REM=0, with no special path.
- MULH sign handling: the high word reflects signed_mode_i, covering MULH, MULHSU and MULHU.
- Kill: kill_i in any state -> IDLE next cycle, with no response. kill_i in DONE drops the pending result. kill_i has priority over accept in the same cycle.
- Backpressure: resp_valid_o stays high and result_o stays stable until resp_ready_i.
- Arithmetic: all internal math is WIDTH+1 bits wide so that |MIN| is representable. Results are truncated to WIDTH bits.

Test Plan:
- MUL signed/signed, -3 × 7, WIDTH=32, dit=1 -> result 0xFFFFFFEB, resp_valid_o exactly 35 cycles after accept.
- MULH cases:
  - signed 0x80000000 × 0x80000000 -> 0x40000000.
  - unsigned 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU (mode=01) -1 × 2 -> 0xFFFFFFFF.
- MUL early-out: 5 × 1 with dit=0 -> 5, resp_valid_o at T+4. Same operands with dit=1 -> T+35.
- DIV/REM cases:
  - signed -7 / 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - 0x80000000 / -1 -> DIV 0x80000000, REM 0.
  - DIV x/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
  - Both /0 cases at T+1 when dit=0, at T+35 when dit=1.
- Handshake and control:
  - kill_i asserted in COMP cycle 10 -> no resp_valid_o; req_ready_o high next cycle; following MUL 6×7 -> 42.
  - resp_ready_i low for 5 cycles in DONE -> result stable, req_ready_o stays 0.
  - kill_i with req_valid_i in IDLE -> request not accepted.
- WIDTH=16 instance: DIV 0xFFF9 / 0x0002 signed -> 0xFFFD, latency 19 cycles with dit=1.
